// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array driver slice.
//   state_e   : one-hot driver FSM state encoding
//   cnt_width : counter width for a range of n values, never below 1 bit
package systolic_pkg;

  typedef enum logic [4:0] {
    IDLE_S  = 5'b00001,
    LOAD_S  = 5'b00010,
    WAIT_S  = 5'b00100,
    DRAIN_S = 5'b01000,
    CLEAR_S = 5'b10000
  } state_e;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_array.sv
// Output-stationary MAC array, array_height_p x array_width_p.
//   row_*   : one operand register per row edge (A[r][k]), ready/valid
//   col_*   : one operand register per column edge (B[k][c]), ready/valid
//   z_*     : per-cell result, valid/yumi, index i = r*W + c
// A k-step fires once every edge register is full; after inner_dim_p steps
// every cell raises z_valid. reset_i clears all operands and accumulators.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int inner_dim_p    = 2
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic [array_height_p-1:0]                        row_valid_i,
  input  logic [array_height_p-1:0][width_p-1:0]           row_data_i,
  output logic [array_height_p-1:0]                        row_ready_o,
  input  logic [array_width_p-1:0]                         col_valid_i,
  input  logic [array_width_p-1:0][width_p-1:0]            col_data_i,
  output logic [array_width_p-1:0]                         col_ready_o,
  output logic [array_height_p*array_width_p-1:0]          z_valid_o,
  output logic [array_height_p*array_width_p-1:0][width_p-1:0] z_data_o,
  input  logic [array_height_p*array_width_p-1:0]          z_yumi_i
);

  localparam int cells_lp = array_height_p * array_width_p;
  localparam int k_w_lp   = cnt_width(inner_dim_p);

  logic [array_height_p-1:0][width_p-1:0] a_q;
  logic [array_height_p-1:0]              a_full_q;
  logic [array_width_p-1:0][width_p-1:0]  b_q;
  logic [array_width_p-1:0]               b_full_q;
  logic [cells_lp-1:0][width_p-1:0]       acc_q;
  logic [cells_lp-1:0]                    z_valid_q;
  logic [k_w_lp-1:0]                      k_q;
  logic                                   fire;
  logic                                   k_last;

  assign fire        = (&a_full_q) & (&b_full_q);
  assign k_last      = (k_q == k_w_lp'(inner_dim_p - 1));
  assign row_ready_o = ~a_full_q;
  assign col_ready_o = ~b_full_q;
  assign z_valid_o   = z_valid_q;
  assign z_data_o    = acc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q       <= '0;
      a_full_q  <= '0;
      b_q       <= '0;
      b_full_q  <= '0;
      acc_q     <= '0;
      z_valid_q <= '0;
      k_q       <= '0;
    end else begin
      for (int unsigned r = 0; r < array_height_p; r++) begin
        if (row_valid_i[r] && !a_full_q[r]) begin
          a_q[r]      <= row_data_i[r];
          a_full_q[r] <= 1'b1;
        end
      end
      for (int unsigned c = 0; c < array_width_p; c++) begin
        if (col_valid_i[c] && !b_full_q[c]) begin
          b_q[c]      <= col_data_i[c];
          b_full_q[c] <= 1'b1;
        end
      end
      // fire needs every register full, so it never coincides with a load
      if (fire) begin
        a_full_q <= '0;
        b_full_q <= '0;
        for (int unsigned r = 0; r < array_height_p; r++) begin
          for (int unsigned c = 0; c < array_width_p; c++) begin
            acc_q[r*array_width_p+c] <= acc_q[r*array_width_p+c] + a_q[r] * b_q[c];
          end
        end
        if (k_last) begin
          k_q       <= '0;
          z_valid_q <= '1;
        end else begin
          k_q <= k_q + k_w_lp'(1);
        end
      end
      for (int unsigned i = 0; i < cells_lp; i++) begin
        if (z_yumi_i[i]) z_valid_q[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/systolic_driver_edge_sequencer.sv
// Operand load sequencer: tracks which array edge the next word targets.
//   clear_i    : zero both counters (job end / abort)
//   adv_i      : a word was accepted this cycle
//   edge_sel_o : one-hot target edge; rows 0..H-1 then columns H..H+W-1
//   last_o     : current target is the final word of the job
module edge_sequencer
  import systolic_pkg::*;
#(
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int inner_dim_p    = 2
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    clear_i,
  input  logic                                    adv_i,
  output logic [array_height_p+array_width_p-1:0] edge_sel_o,
  output logic                                    last_o
);

  localparam int edges_lp  = array_height_p + array_width_p;
  localparam int edge_w_lp = cnt_width(edges_lp);
  localparam int k_w_lp    = cnt_width(inner_dim_p);

  logic [edge_w_lp-1:0] edge_q;
  logic [k_w_lp-1:0]    k_q;
  logic                 edge_last;
  logic                 k_last;

  assign edge_last = (edge_q == edge_w_lp'(edges_lp - 1));
  assign k_last    = (k_q == k_w_lp'(inner_dim_p - 1));
  assign last_o    = edge_last & k_last;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      edge_q <= '0;
      k_q    <= '0;
    end else if (adv_i) begin
      if (edge_last) begin
        edge_q <= '0;
        k_q    <= k_last ? '0 : k_q + k_w_lp'(1);
      end else begin
        edge_q <= edge_q + edge_w_lp'(1);
      end
    end
  end

  always_comb begin
    edge_sel_o = '0;
    for (int unsigned i = 0; i < edges_lp; i++) begin
      edge_sel_o[i] = (edge_q == edge_w_lp'(i));
    end
  end

endmodule

// File: rtl/systolic_driver.sv
// Stream driver for systolic_array computing C = A*B.
//   ready_o/valid_i/data_i : operand stream, per k: A[0..H-1][k], B[k][0..W-1]
//   valid_o/yumi_i/data_o  : results C row-major
//   en_i    : stall everything when low
//   flush_i : abort the running job via one CLEAR_S cycle
//   busy_o  : a job is in progress
module systolic_driver
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int inner_dim_p    = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               flush_i,
  output logic               ready_o,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               busy_o
);

  localparam int cells_lp = array_height_p * array_width_p;
  localparam int edges_lp = array_height_p + array_width_p;
  localparam int idx_w_lp = cnt_width(cells_lp);

  state_e state_q, state_n;
  logic [idx_w_lp-1:0] idx_q;

  logic [edges_lp-1:0]                      edge_sel, edge_ready, edge_valid;
  logic [array_height_p-1:0]                row_ready;
  logic [array_width_p-1:0]                 col_ready;
  logic [array_height_p-1:0][width_p-1:0]   row_data;
  logic [array_width_p-1:0][width_p-1:0]    col_data;
  logic [cells_lp-1:0]                      z_valid, z_yumi;
  logic [cells_lp-1:0][width_p-1:0]         z_data;
  logic load_last, loading, hs, take, drain_last, clearing, array_reset;

  assign clearing    = (state_q == CLEAR_S);
  assign array_reset = reset_i | clearing;
  assign loading     = (state_q == LOAD_S) & en_i;
  assign edge_ready  = {col_ready, row_ready};
  assign ready_o     = loading & |(edge_sel & edge_ready);
  assign hs          = valid_i & ready_o;
  assign edge_valid  = edge_sel & {edges_lp{valid_i & loading}};
  assign row_data    = {array_height_p{data_i}};
  assign col_data    = {array_width_p{data_i}};
  assign take        = (state_q == DRAIN_S) & en_i & yumi_i;
  assign drain_last  = (idx_q == idx_w_lp'(cells_lp - 1));
  assign valid_o     = (state_q == DRAIN_S) & en_i;
  assign busy_o      = (state_q != IDLE_S);

  edge_sequencer #(
    .array_width_p (array_width_p),
    .array_height_p(array_height_p),
    .inner_dim_p   (inner_dim_p)
  ) u_seq (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (clearing),
    .adv_i     (hs),
    .edge_sel_o(edge_sel),
    .last_o    (load_last)
  );

  systolic_array #(
    .width_p       (width_p),
    .array_width_p (array_width_p),
    .array_height_p(array_height_p),
    .inner_dim_p   (inner_dim_p)
  ) u_array (
    .clk_i      (clk_i),
    .reset_i    (array_reset),
    .row_valid_i(edge_valid[array_height_p-1:0]),
    .row_data_i (row_data),
    .row_ready_o(row_ready),
    .col_valid_i(edge_valid[edges_lp-1:array_height_p]),
    .col_data_i (col_data),
    .col_ready_o(col_ready),
    .z_valid_o  (z_valid),
    .z_data_o   (z_data),
    .z_yumi_i   (z_yumi)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE_S;
    else if (en_i) state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE_S:  if (valid_i) state_n = LOAD_S;
      LOAD_S:  if (hs && load_last) state_n = WAIT_S;
      WAIT_S:  if (&z_valid) state_n = DRAIN_S;
      DRAIN_S: if (take && drain_last) state_n = CLEAR_S;
      CLEAR_S: state_n = IDLE_S;
      default: state_n = IDLE_S;
    endcase
    if (flush_i && state_q != IDLE_S) state_n = CLEAR_S;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clearing) idx_q <= '0;
    else if (take && !drain_last) idx_q <= idx_q + idx_w_lp'(1);
  end

  // out-of-range index leaves data_o at zero
  always_comb begin
    data_o = '0;
    z_yumi = '0;
    for (int unsigned i = 0; i < cells_lp; i++) begin
      if (idx_q == idx_w_lp'(i)) begin
        z_yumi[i] = take;
        if (state_q == DRAIN_S) data_o = z_data[i];
      end
    end
  end

endmodule

// File: tb/tb_systolic_driver.sv
module tb_systolic_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, flush, valid_i, yumi;
  logic [31:0] data_i;
  logic        ready, valid_o, busy;
  logic [31:0] data_o;

  logic        w_en, w_flush, w_valid_i, w_yumi;
  logic [7:0]  w_data_i;
  logic        w_ready, w_valid_o, w_busy;
  logic [7:0]  w_data_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] A [2][2];
  logic [31:0] B [2][2];
  logic [31:0] words_q[$];
  logic [31:0] exp_q[$];

  systolic_driver dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush),
    .ready_o(ready), .valid_i(valid_i), .data_i(data_i),
    .valid_o(valid_o), .yumi_i(yumi), .data_o(data_o), .busy_o(busy)
  );

  systolic_driver #(
    .width_p(8), .array_width_p(2), .array_height_p(3), .inner_dim_p(3)
  ) dut_w (
    .clk_i(clk), .reset_i(reset), .en_i(w_en), .flush_i(w_flush),
    .ready_o(w_ready), .valid_i(w_valid_i), .data_i(w_data_i),
    .valid_o(w_valid_o), .yumi_i(w_yumi), .data_o(w_data_o), .busy_o(w_busy)
  );

  // Reference: operand stream order and C = A*B mod 2^32 from A/B directly.
  task automatic make_job();
    logic [31:0] s;
    words_q.delete();
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 2; r++) words_q.push_back(A[r][k]);
      for (int c = 0; c < 2; c++) words_q.push_back(B[k][c]);
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s = s + A[r][k] * B[k][c];
        exp_q.push_back(s);
      end
  endtask

  task automatic rand_ab();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        A[r][c] = $urandom;
        B[r][c] = $urandom;
      end
  endtask

  task automatic send_words(input int n, input bit gap);
    int idx = 0;
    int budget = 400;
    bit took;
    while (idx < n && budget > 0) begin
      valid_i = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_i  = words_q[idx];
      #1;
      took = valid_i && ready;
      @(posedge clk); #1;
      if (took) idx++;
      budget--;
    end
    valid_i = 1'b0;
    total++;
    if (idx != n) begin
      bad++;
      $display("FAIL send_words: accepted=%0d required=%0d", idx, n);
    end
  endtask

  // mode 0: yumi whenever valid; mode 1: yumi one cycle in three
  task automatic collect(input int n, input int mode, input bit check_end);
    int j = 0;
    int budget = 400;
    int cyc = 0;
    bit held = 0;
    logic [31:0] hv = 0;
    while (j < n && budget > 0) begin
      total++;
      if (ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_outside_load: ready=%b required=0", ready);
      end
      if (valid_o) begin
        if (held) begin
          total++;
          if (data_o !== hv) begin
            bad++;
            $display("FAIL data_stable: data_o=%0d required=%0d", data_o, hv);
          end
        end
        yumi = (mode == 0) || (cyc % 3 == 0);
        if (yumi) begin
          total++;
          if (data_o !== exp_q[j]) begin
            bad++;
            $display("FAIL result[%0d]: data_o=%0d required=%0d", j, data_o, exp_q[j]);
          end
          j++;
          held = 0;
        end else begin
          held = 1;
          hv = data_o;
        end
      end
      cyc++;
      @(posedge clk); #1;
      yumi = 1'b0;
      budget--;
    end
    total++;
    if (j != n) begin
      bad++;
      $display("FAIL collect_timeout: got=%0d required=%0d", j, n);
    end
    if (check_end) begin
      total++;
      if (busy !== 1'b1 || valid_o !== 1'b0) begin
        bad++;
        $display("FAIL clear_cycle: busy=%b valid_o=%b required busy=1 valid_o=0", busy, valid_o);
      end
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_clear: busy=%b required=0", busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; flush = 1'b0; valid_i = 1'b0; yumi = 1'b0; data_i = '0;
    w_en = 1'b1; w_flush = 1'b0; w_valid_i = 1'b0; w_yumi = 1'b0; w_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid_o=%b data_o=%0d busy=%b required 0 0 0 0",
               ready, valid_o, data_o, busy);
    end
    total++;
    if (w_ready !== 1'b0 || w_valid_o !== 1'b0 || w_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_wide: ready=%b valid_o=%b busy=%b required 0 0 0", w_ready, w_valid_o, w_busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    A = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    B = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
    make_job();
    send_words(8, 1'b0);
    collect(4, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    A = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
    B = '{'{32'd5, 32'd6}, '{32'd7, 32'd8}};
    make_job();
    send_words(8, 1'b0);
    collect(4, 1, 1'b1);
  endtask

  task automatic test_gapped();
    for (int n = 0; n < 3; n++) begin
      rand_ab();
      make_job();
      send_words(8, 1'b1);
      collect(4, n % 2, 1'b1);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_in_idle: busy=%b required=0", busy);
    end
    rand_ab();
    make_job();
    send_words(5, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b1 || ready !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: busy=%b ready=%b valid_o=%b required 1 0 0", busy, ready, valid_o);
    end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle: busy=%b required=0", busy);
    end
    A = '{'{32'd1, 32'd0}, '{32'd0, 32'd1}};
    B = '{'{32'd9, 32'd8}, '{32'd7, 32'd6}};
    make_job();
    send_words(8, 1'b0);
    collect(4, 0, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    rand_ab();
    make_job();
    send_words(8, 1'b0);
    collect(2, 0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (valid_o !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_drain: valid_o=%b busy=%b required 0 0", valid_o, busy);
    end
    rand_ab();
    make_job();
    send_words(8, 1'b0);
    collect(4, 0, 1'b1);
  endtask

  task automatic test_wide();
    int idx = 0;
    int budget = 400;
    int got = 0;
    int s = 0;
    bit took;
    logic [7:0] e;
    for (int k = 0; k < 3; k++) s = s + 255 * 255;
    e = 8'(s % 256);
    while (idx < 15 && budget > 0) begin
      w_valid_i = 1'b1;
      w_data_i  = 8'd255;
      #1;
      took = w_ready;
      @(posedge clk); #1;
      if (took) idx++;
      budget--;
    end
    w_valid_i = 1'b0;
    total++;
    if (idx != 15) begin
      bad++;
      $display("FAIL wide_load: accepted=%0d required=15", idx);
    end
    budget = 400;
    while (got < 6 && budget > 0) begin
      if (got == 2) begin
        w_en = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          total++;
          if (w_valid_o !== 1'b0 || w_data_o !== e || w_busy !== 1'b1) begin
            bad++;
            $display("FAIL wide_en_stall: valid_o=%b data_o=%0d busy=%b required 0 %0d 1",
                     w_valid_o, w_data_o, w_busy, e);
          end
        end
        w_en = 1'b1;
        #1;
      end
      if (w_valid_o) begin
        w_yumi = 1'b1;
        total++;
        if (w_data_o !== e) begin
          bad++;
          $display("FAIL wide_result[%0d]: data_o=%0d required=%0d", got, w_data_o, e);
        end
        got++;
      end
      @(posedge clk); #1;
      w_yumi = 1'b0;
      budget--;
    end
    total++;
    if (got != 6) begin
      bad++;
      $display("FAIL wide_count: got=%0d required=6", got);
    end
    total++;
    if (w_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wide_extra_output: valid_o=%b required=0", w_valid_o);
    end
    @(posedge clk); #1;
    total++;
    if (w_busy !== 1'b0) begin
      bad++;
      $display("FAIL wide_idle: busy=%b required=0", w_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_basic();
    test_gapped();
    test_flush();
    test_reset_mid_drain();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
